// File: rtl/pe_triple_feeder.sv
// pe_triple_feeder: initiator side of the PE reducer start/finish handshake.
// Buffers sparse (addr, w, ia, last) entries in a small FIFO and issues them
// in groups of three; a group never crosses a tile boundary, short groups are
// padded with copies of the last real address carrying zero weight/activation.
// Optional watchdog on the finish handshake: define PE_FEEDER_TIMEOUT_EN.
module pe_triple_feeder #(
  parameter int DEPTH  = 8,
  parameter int AW     = 7,
  parameter int DW     = 16,
  parameter int TO_CYC = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3*AW-1:0] i_addr,
  input  logic [DW-1:0]   i_w,
  input  logic [DW-1:0]   i_ia,
  input  logic            i_last,
  output logic            o_start,
  output logic [9*AW-1:0] o_addr,
  output logic [3*DW-1:0] o_w,
  output logic [3*DW-1:0] o_ia,
  input  logic            i_finish,
  output logic            o_done,
  output logic            o_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 3*AW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT} state_t;
  state_t state;

  logic [EW-1:0]   mem_addr [DEPTH];
  logic [DW-1:0]   mem_w    [DEPTH];
  logic [DW-1:0]   mem_ia   [DEPTH];
  logic            mem_last [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic [1:0]      k;          // real entries in the group at the FIFO head
  logic [1:0]      pop_k;      // entries consumed this cycle (only in S_LOAD)
  logic [PW-1:0]   hidx [3];
  logic [2:0]      hd_last;
  logic            grp_ready;
  logic [9*AW-1:0] g_addr;
  logic [3*DW-1:0] g_w, g_ia;
  logic            g_tile_end;
  logic            tile_end;

`ifdef PE_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] wd_cnt;
  logic          err;
  assign o_err = err;
`else
  assign o_err = 1'b0;
`endif

  assign push    = i_valid && o_ready;
  assign o_ready = (count < CW'(DEPTH));
  assign pop_k   = (state == S_LOAD) ? k : 2'd0;
  assign o_done  = (state == S_WAIT) && tile_end && i_finish;

  // Look at the three head entries and form the candidate group from them.
  always_comb begin
    g_addr = '0;
    g_w    = '0;
    g_ia   = '0;
    for (int j = 0; j < 3; j++) begin
      hidx[j]    = rd_ptr + PW'(j);
      hd_last[j] = mem_last[hidx[j]];
    end
    // A last flag in slot 0 or 1 closes the group early; slot 2 closes it anyway.
    if (hd_last[0])      k = 2'd1;
    else if (hd_last[1]) k = 2'd2;
    else                 k = 2'd3;
    // Only flags of entries actually present may trigger an early group.
    grp_ready = (count >= CW'(3)) ||
                ((count >= CW'(1)) && hd_last[0]) ||
                ((count >= CW'(2)) && hd_last[1]);
    for (int j = 0; j < 3; j++) begin
      if (2'(j) < k) begin
        g_addr[EW*j +: EW] = mem_addr[hidx[j]];
        g_w[DW*j +: DW]    = mem_w[hidx[j]];
        g_ia[DW*j +: DW]   = mem_ia[hidx[j]];
      end else begin
        // Pad merges into the last real address with zero contribution.
        g_addr[EW*j +: EW] = mem_addr[hidx[k - 2'd1]];
      end
    end
    g_tile_end = hd_last[k - 2'd1];
  end

  // Entry storage; occupancy is tracked by count, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= i_addr;
      mem_w[wr_ptr]    <= i_w;
      mem_ia[wr_ptr]   <= i_ia;
      mem_last[wr_ptr] <= i_last;
    end
  end

  // Pointers and occupancy; a push and a group pop may share a cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop_k);
      count  <= count + CW'(push) - CW'(pop_k);
    end
  end

  // Issue FSM with registered group outputs and start pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      o_start  <= 1'b0;
      o_addr   <= '0;
      o_w      <= '0;
      o_ia     <= '0;
      tile_end <= 1'b0;
`ifdef PE_FEEDER_TIMEOUT_EN
      wd_cnt   <= '0;
      err      <= 1'b0;
`endif
    end else begin
      o_start <= 1'b0;
      case (state)
        S_IDLE: if (grp_ready) state <= S_LOAD;
        S_LOAD: begin
          o_addr   <= g_addr;
          o_w      <= g_w;
          o_ia     <= g_ia;
          tile_end <= g_tile_end;
          o_start  <= 1'b1;
          state    <= S_ISSUE;
        end
        S_ISSUE: begin
          state  <= S_WAIT;
`ifdef PE_FEEDER_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (i_finish) state <= S_IDLE;
`ifdef PE_FEEDER_TIMEOUT_EN
          // Reducer never answered: drop the group and flag it.
          else if (wd_cnt == TW'(TO_CYC - 1)) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else wd_cnt <= wd_cnt + TW'(1);
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_triple_feeder.sv
// Testbench for pe_triple_feeder: drives entry streams, acts as the reducer,
// and checks each issued group against a stream-grouping reference model.
module tb_pe_triple_feeder;
  localparam int DEPTH = 8, AW = 7, DW = 16, TO_CYC = 255, EW = 3*AW;

  typedef struct packed {
    logic [EW-1:0] addr;
    logic [DW-1:0] w;
    logic [DW-1:0] ia;
    logic          last;
  } ent_t;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1, i_valid = 1'b0, i_last = 1'b0, i_finish = 1'b0;
  logic [EW-1:0]   i_addr = '0;
  logic [DW-1:0]   i_w = '0, i_ia = '0;
  logic            o_ready, o_start, o_done, o_err;
  logic [9*AW-1:0] o_addr;
  logic [3*DW-1:0] o_w, o_ia;

  ent_t mq[$];          // entries accepted but not yet issued, in order
  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, start_cnt = 0, start_cyc = 0, served = 0;

  pe_triple_feeder #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TO_CYC(TO_CYC)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_w(i_w), .i_ia(i_ia), .i_last(i_last),
    .o_start(o_start), .o_addr(o_addr), .o_w(o_w), .o_ia(o_ia),
    .i_finish(i_finish), .o_done(o_done), .o_err(o_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Record every start pulse so a pulse during stimulus is never missed.
  always @(negedge clk) if (o_start) begin
    start_cnt <= start_cnt + 1;
    start_cyc <= cyc;
  end

  function automatic ent_t mk(input int a, input int w, input int ia, input bit l);
    ent_t e;
    e.addr = EW'(a); e.w = DW'(w); e.ia = DW'(ia); e.last = l;
    return e;
  endfunction

  function automatic ent_t rnd(input bit l);
    return mk(int'($urandom_range(0, 7)), int'($urandom), int'($urandom), l);
  endfunction

  // Present one entry for one cycle; accepted entries join the model queue.
  task automatic push_ent(input ent_t e, output logic acc);
    i_valid = 1'b1; i_addr = e.addr; i_w = e.w; i_ia = e.ia; i_last = e.last;
    @(negedge clk); acc = o_ready;
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0;
    if (acc) mq.push_back(e);
  endtask

  // Act as the reducer for one group: wait for start, check the group against
  // the model, hold it for d cycles, then finish (or reset mid-group).
  task automatic serve(input int d, input bit rst_mid, output int scyc);
    logic [9*AW-1:0] ea;
    logic [3*DW-1:0] ew, eia;
    logic edone;
    ent_t s[3];
    int k;
    bit ok;
    ok = 1'b0; scyc = -1;
    for (int i = 0; i < 80; i++) begin
      if (start_cnt != served) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    total_cnt++;
    if (!ok) begin $display("FAIL start_wait got no o_start in 80 cycles, need 1"); return; end
    pass_cnt++;
    served++; scyc = start_cyc;
    // Model: up to three entries, stopping right after a last entry.
    k = 0;
    while (k < 3 && mq.size() > 0) begin
      s[k] = mq.pop_front(); k++;
      if (s[k-1].last) break;
    end
    total_cnt++;
    if (k == 0) begin $display("FAIL grp_model issued group with 0 queued entries"); return; end
    pass_cnt++;
    ea = '0; ew = '0; eia = '0;
    for (int j = 0; j < 3; j++) begin
      if (j < k) begin
        ea[EW*j +: EW] = s[j].addr; ew[DW*j +: DW] = s[j].w; eia[DW*j +: DW] = s[j].ia;
      end else ea[EW*j +: EW] = s[k-1].addr;
    end
    edone = s[k-1].last;
    total_cnt++;
    if (o_addr !== ea) $display("FAIL grp_addr got %h need %h", o_addr, ea); else pass_cnt++;
    total_cnt++;
    if ({o_w, o_ia} !== {ew, eia}) $display("FAIL grp_data got %h/%h need %h/%h", o_w, o_ia, ew, eia);
    else pass_cnt++;
    total_cnt++;
    if (o_start !== 1'b0) $display("FAIL start_pulse o_start still %b, need 0", o_start); else pass_cnt++;
    if (rst_mid) begin
      i_rst = 1'b1; @(posedge clk); #1; i_rst = 1'b0; i_finish = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({o_start, o_addr, o_w, o_ia} !== '0)
        $display("FAIL rst_outs got %b %h %h %h need all 0", o_start, o_addr, o_w, o_ia);
      else pass_cnt++;
      total_cnt++;
      if ({o_done, o_ready, o_err} !== 3'b010)
        $display("FAIL rst_flags done/ready/err got %b need 010", {o_done, o_ready, o_err});
      else pass_cnt++;
      @(posedge clk); #1; i_finish = 1'b0;
      mq.delete();
      return;
    end
    repeat (d) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({o_start, o_done, o_addr, o_w, o_ia} !== {2'b00, ea, ew, eia})
        $display("FAIL hold got st=%b dn=%b %h need frozen %h", o_start, o_done, o_addr, ea);
      else pass_cnt++;
    end
    i_finish = 1'b1; #1;
    total_cnt++;
    if (o_done !== edone) $display("FAIL done got %b need %b", o_done, edone); else pass_cnt++;
    @(posedge clk); #1; i_finish = 1'b0;
  endtask

  task automatic drain();
    int sc;
    while (mq.size() > 0) begin
      serve(int'($urandom_range(1, 4)), 1'b0, sc);
      if (sc < 0) begin mq.delete(); break; end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; i_rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({o_ready, o_start, o_done, o_err} !== 4'b1000)
      $display("FAIL reset_flags rdy/st/dn/err got %b need 1000", {o_ready, o_start, o_done, o_err});
    else pass_cnt++;
    total_cnt++;
    if ({o_addr, o_w, o_ia} !== '0) $display("FAIL reset_group got %h %h %h need 0", o_addr, o_w, o_ia);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_single_group();
    logic acc; int pc, sc;
    push_ent(mk(1, 2, 5, 0), acc);
    push_ent(mk(1, 3, 5, 0), acc);
    push_ent(mk(2, 4, 5, 1), acc);
    pc = cyc;
    serve(1, 1'b0, sc);
    total_cnt++;
    if (sc !== pc + 2) $display("FAIL start_latency got cycle %0d need %0d", sc, pc + 2); else pass_cnt++;
  endtask

  task automatic test_split_tile();
    logic acc;
    for (int i = 0; i < 4; i++) push_ent(rnd(i == 3), acc);
    drain();
  endtask

  task automatic test_early_last();
    logic acc;
    for (int i = 0; i < 5; i++) push_ent(rnd(i == 0 || i == 4), acc);
    drain();
  endtask

  task automatic test_back_to_back();
    logic acc; int sc[4];
    for (int i = 0; i < 10; i++) push_ent(rnd(i == 9), acc);
    for (int g = 0; g < 4; g++) serve(1, 1'b0, sc[g]);
    for (int g = 2; g < 4; g++) begin
      total_cnt++;
      if (sc[g] - sc[g-1] !== 5) $display("FAIL issue_period got %0d need 5", sc[g] - sc[g-1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_full();
    logic acc; bit ok;
    for (int i = 0; i < 3; i++) push_ent(rnd(i == 2), acc);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start_cnt != served) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    total_cnt++;
    if (!ok) $display("FAIL full_start got no o_start in 20 cycles, need 1"); else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      push_ent(rnd(i == DEPTH - 1 || $urandom_range(0, 3) == 0), acc);
      total_cnt++;
      if (acc !== 1'b1) $display("FAIL full_accept entry %0d ready=%b need 1", i, acc); else pass_cnt++;
    end
    push_ent(mk(99, 99, 99, 1), acc);
    total_cnt++;
    if (acc !== 1'b0) $display("FAIL full_ready got %b need 0", acc); else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid();
    logic acc; int sc;
    for (int i = 0; i < 5; i++) push_ent(rnd(i == 2), acc);
    serve(1, 1'b1, sc);
    for (int i = 0; i < 3; i++) push_ent(rnd(i == 2), acc);
    drain();
  endtask

  task automatic test_random();
    logic acc; int n;
    for (int b = 0; b < 8; b++) begin
      n = int'($urandom_range(1, 7));
      for (int i = 0; i < n; i++) begin
        push_ent(rnd(i == n - 1 || $urandom_range(0, 3) == 0), acc);
        total_cnt++;
        if (acc !== 1'b1) $display("FAIL rand_accept batch %0d ready=%b need 1", b, acc); else pass_cnt++;
      end
      drain();
    end
    total_cnt++;
    if (o_err !== 1'b0) $display("FAIL err_idle got %b need 0", o_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_split_tile();
    test_early_last();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
